// File: rtl/mem_access_unit_pkg.sv
// Command and state encodings shared by the MEM stage and its load extender.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mem_access_unit_pkg;

    localparam int CMD_W = 5;

    // Decoded command bus from EX/MEM. Codes not listed are non-memory commands.
    typedef enum logic [CMD_W-1:0] {
        CMD_NOP  = 5'h00,
        CMD_ADD  = 5'h01,
        CMD_ADDI = 5'h02,
        CMD_LB   = 5'h10,
        CMD_LH   = 5'h11,
        CMD_LW   = 5'h12,
        CMD_LBU  = 5'h13,
        CMD_LHU  = 5'h14,
        CMD_SB   = 5'h18,
        CMD_SH   = 5'h19,
        CMD_SW   = 5'h1A
    } cmd_e;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_XFER  = 2'd1,
        MEM_DRAIN = 2'd2,
        MEM_DONE  = 2'd3
    } mem_state_e;

    function automatic logic is_load_cmd(input logic [CMD_W-1:0] c);
        case (c)
            CMD_LB, CMD_LH, CMD_LW, CMD_LBU, CMD_LHU: is_load_cmd = 1'b1;
            default:                                  is_load_cmd = 1'b0;
        endcase
    endfunction

    function automatic logic is_store_cmd(input logic [CMD_W-1:0] c);
        case (c)
            CMD_SB, CMD_SH, CMD_SW: is_store_cmd = 1'b1;
            default:                is_store_cmd = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_cmd(input logic [CMD_W-1:0] c);
        is_mem_cmd = is_load_cmd(c) || is_store_cmd(c);
    endfunction

    // Index of the final byte of a transfer (transfer length minus one).
    function automatic logic [1:0] last_byte_idx(input logic [CMD_W-1:0] c);
        case (c)
            CMD_LH, CMD_LHU, CMD_SH: last_byte_idx = 2'd1;
            CMD_LW, CMD_SW:          last_byte_idx = 2'd3;
            default:                 last_byte_idx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Sign/zero extension of assembled little-endian load data to register width.
// Latency: combinational.
// Backpressure: none.
//   cmd    : latched load command (selects width and signedness)
//   raw    : assembled bytes, byte 0 in raw[7:0]
//   result : value written back to the register file
module mem_access_unit_load_extender
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [CMD_W-1:0]  cmd,
    input  logic [31:0]       raw,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (cmd)
            CMD_LB:  result = DATA_W'($signed(raw[7:0]));
            CMD_LBU: result = DATA_W'(raw[7:0]);
            CMD_LH:  result = DATA_W'($signed(raw[15:0]));
            CMD_LHU: result = DATA_W'(raw[15:0]);
            CMD_LW:  result = DATA_W'(raw);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: runs loads/stores over a byte-wide port, passes other commands through.
// Latency: non-memory 1 cycle; N-byte load N+2 and store N+1 cycles from command accept to DONE (gnt held high).
// Backpressure: stall_o freezes upstream while busy; gnt low holds the current byte (address stable, no write).
//
// Ports
//   clk_in, rst_in                     clock, synchronous active-high reset
//   cmdtype_in .. write_rsd_in         EX/MEM bundle (command, address, store data, rd info)
//   mem_req_o/mem_gnt_i                byte-port request and grant; a byte moves when both are high
//   mem_a_o/mem_wr_o/mem_dout_o        byte address, write strobe, write byte
//   mem_din_i                          read byte, valid the cycle after an accepted read
//   stall_o                            freezes IF/ID/EX and EX/MEM
//   rsd_addr_o/rsd_data_o/write_rsd_o  MEM/WB bundle (registered)
// Optional (macro MEM_FORWARD_EN): mem_forward_o/mem_forward_addr_o/mem_forward_data_o
//   expose the registered MEM result for ID bypass.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [CMD_W-1:0]   cmdtype_in,
    input  logic [ADDR_W-1:0]  mem_addr_in,
    input  logic [DATA_W-1:0]  mem_val_in,
    input  logic [4:0]         rsd_addr_in,
    input  logic [DATA_W-1:0]  rsd_data_in,
    input  logic               write_rsd_in,
    output logic               mem_req_o,
    input  logic               mem_gnt_i,
    output logic [ADDR_W-1:0]  mem_a_o,
    output logic               mem_wr_o,
    output logic [7:0]         mem_dout_o,
    input  logic [7:0]         mem_din_i,
    output logic               stall_o,
    output logic [4:0]         rsd_addr_o,
    output logic [DATA_W-1:0]  rsd_data_o,
    output logic               write_rsd_o
`ifdef MEM_FORWARD_EN
    ,
    output logic               mem_forward_o,
    output logic [4:0]         mem_forward_addr_o,
    output logic [DATA_W-1:0]  mem_forward_data_o
`endif
);

    // Copy of the EX/MEM bundle taken when a memory command is accepted;
    // upstream inputs are ignored until the transfer finishes.
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
        logic [3:0][7:0]   val;
        logic [4:0]        rsd_addr;
        logic [DATA_W-1:0] rsd_data;
        logic              write_rsd;
    } mem_req_t;

    mem_state_e        state;
    mem_req_t          req_q;
    logic [1:0]        issue_idx;   // next byte to put on the port
    logic [1:0]        recv_idx;    // next byte slot to fill from mem_din_i
    logic              rd_pend;     // a read was accepted last cycle; mem_din_i is valid now
    logic [3:0][7:0]   rx_buf;

    logic              in_mem;
    logic              q_load;
    logic              q_store;
    logic [1:0]        last_idx;
    logic              accept;
    logic [3:0][7:0]   rx_merged;
    logic [DATA_W-1:0] ld_result;

    assign in_mem   = is_mem_cmd(cmdtype_in);
    assign q_load   = is_load_cmd(req_q.cmd);
    assign q_store  = is_store_cmd(req_q.cmd);
    assign last_idx = last_byte_idx(req_q.cmd);

    assign mem_req_o = (state == MEM_XFER);
    assign accept    = mem_req_o && mem_gnt_i;

    // Address is derived only from registered state, so it stays put while gnt is low.
    // Wraparound past the top of the address space falls out of the modular add.
    assign mem_a_o    = mem_req_o ? (req_q.addr + ADDR_W'(issue_idx)) : '0;
    assign mem_wr_o   = accept && q_store;
    assign mem_dout_o = (mem_req_o && q_store) ? req_q.val[issue_idx] : 8'h00;

    // The stall must rise in the same cycle the memory command appears, otherwise
    // EX/MEM would advance underneath it. It drops in DONE so the pipeline moves on.
    assign stall_o = !rst_in &&
                     (((state == MEM_IDLE) && in_mem) ||
                      (state == MEM_XFER) || (state == MEM_DRAIN));

    // Final read byte arrives in DRAIN; merge it here so the result can be
    // registered on the same edge that enters DONE.
    always_comb begin
        rx_merged = rx_buf;
        if (rd_pend) begin
            rx_merged[recv_idx] = mem_din_i;
        end
    end

    mem_access_unit_load_extender #(
        .DATA_W (DATA_W)
    ) u_load_ext (
        .cmd    (req_q.cmd),
        .raw    (rx_merged),
        .result (ld_result)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= MEM_IDLE;
            req_q       <= '0;
            issue_idx   <= '0;
            recv_idx    <= '0;
            rd_pend     <= 1'b0;
            rx_buf      <= '0;
            rsd_addr_o  <= '0;
            rsd_data_o  <= '0;
            write_rsd_o <= 1'b0;
        end else begin
            rd_pend <= accept && q_load;

            // Captures follow accepted reads one cycle later, independent of
            // any grant gaps on the issue side.
            if (rd_pend) begin
                rx_buf[recv_idx] <= mem_din_i;
                recv_idx         <= recv_idx + 2'd1;
            end

            case (state)
                MEM_IDLE: begin
                    if (in_mem) begin
                        req_q.cmd       <= cmdtype_in;
                        req_q.addr      <= mem_addr_in;
                        req_q.val       <= mem_val_in[31:0];
                        req_q.rsd_addr  <= rsd_addr_in;
                        req_q.rsd_data  <= rsd_data_in;
                        req_q.write_rsd <= write_rsd_in;
                        issue_idx       <= '0;
                        recv_idx        <= '0;
                        rx_buf          <= '0;
                        // Bubble into MEM/WB while the transfer runs.
                        rsd_addr_o      <= '0;
                        rsd_data_o      <= '0;
                        write_rsd_o     <= 1'b0;
                        state           <= MEM_XFER;
                    end else begin
                        rsd_addr_o  <= rsd_addr_in;
                        rsd_data_o  <= rsd_data_in;
                        write_rsd_o <= write_rsd_in;
                    end
                end

                MEM_XFER: begin
                    if (accept) begin
                        issue_idx <= issue_idx + 2'd1;
                        if (issue_idx == last_idx) begin
                            if (q_load) begin
                                state <= MEM_DRAIN;
                            end else begin
                                rsd_addr_o  <= req_q.rsd_addr;
                                rsd_data_o  <= req_q.rsd_data;
                                write_rsd_o <= 1'b0;
                                state       <= MEM_DONE;
                            end
                        end
                    end
                end

                MEM_DRAIN: begin
                    if (rd_pend) begin
                        rsd_addr_o  <= req_q.rsd_addr;
                        rsd_data_o  <= ld_result;
                        write_rsd_o <= req_q.write_rsd;
                        state       <= MEM_DONE;
                    end
                end

                MEM_DONE: begin
                    // Result is presented for one cycle only. The finished command
                    // is still on the inputs this cycle and must not be re-issued.
                    rsd_addr_o  <= '0;
                    rsd_data_o  <= '0;
                    write_rsd_o <= 1'b0;
                    state       <= MEM_IDLE;
                end

                default: state <= MEM_IDLE;
            endcase
        end
    end

`ifdef MEM_FORWARD_EN
    assign mem_forward_o      = write_rsd_o && (rsd_addr_o != 5'd0);
    assign mem_forward_addr_o = rsd_addr_o;
    assign mem_forward_data_o = rsd_data_o;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed commands, byte-memory model,
// scoreboard queues for byte accesses and MEM/WB results checked by a negedge monitor.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  cmd;
    logic [31:0] addr_in, val_in, rdata_in;
    logic [4:0]  rd_in;
    logic        wr_in;
    logic        mem_req, gnt, mem_wr;
    logic [31:0] mem_a;
    logic [7:0]  dout, din;
    logic        stall;
    logic [4:0]  rd_o;
    logic [31:0] rdata_o;
    logic        wrsd_o;
`ifdef MEM_FORWARD_EN
    logic        fwd;
    logic [4:0]  fwd_a;
    logic [31:0] fwd_d;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
    } acc_t;
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    acc_t exp_acc[$];
    res_t exp_res[$];
    logic [7:0] mem [logic [31:0]];

    mem_access_unit dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .cmdtype_in   (cmd),
        .mem_addr_in  (addr_in),
        .mem_val_in   (val_in),
        .rsd_addr_in  (rd_in),
        .rsd_data_in  (rdata_in),
        .write_rsd_in (wr_in),
        .mem_req_o    (mem_req),
        .mem_gnt_i    (gnt),
        .mem_a_o      (mem_a),
        .mem_wr_o     (mem_wr),
        .mem_dout_o   (dout),
        .mem_din_i    (din),
        .stall_o      (stall),
        .rsd_addr_o   (rd_o),
        .rsd_data_o   (rdata_o),
        .write_rsd_o  (wrsd_o)
`ifdef MEM_FORWARD_EN
        ,
        .mem_forward_o      (fwd),
        .mem_forward_addr_o (fwd_a),
        .mem_forward_data_o (fwd_d)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte memory: read data returned the cycle after an accepted read, junk otherwise.
    always @(posedge clk) begin
        if (mem_req && gnt && !mem_wr)
            din <= mem.exists(mem_a) ? mem[mem_a] : 8'h00;
        else
            din <= 8'($urandom);
        if (mem_req && gnt && mem_wr)
            mem[mem_a] = dout;
    end

    // Monitor: pop expected accesses / results whenever the DUT presents them.
    always @(negedge clk) begin
        acc_t e;
        res_t r;
        if (mem_req && gnt) begin
            if (exp_acc.size() == 0) begin
                checks++; errors++;
                $display("FAIL acc_unexpected: got addr %h wr %0d, none expected", mem_a, mem_wr);
            end else begin
                e = exp_acc.pop_front();
                chk("acc_addr", mem_a, e.a);
                chk("acc_wr", 32'(mem_wr), 32'(e.wr));
                if (e.wr) chk("acc_wdata", 32'(dout), 32'(e.d));
            end
        end else if (mem_req) begin
            chk("gntlow_wr", 32'(mem_wr), 32'd0);
            if (exp_acc.size() != 0) chk("gntlow_addr", mem_a, exp_acc[0].a);
        end
        if (wrsd_o) begin
            if (exp_res.size() == 0) begin
                checks++; errors++;
                $display("FAIL res_unexpected: got rd %0d data %h, none expected", rd_o, rdata_o);
            end else begin
                r = exp_res.pop_front();
                chk("res_rd", 32'(rd_o), 32'(r.rd));
                chk("res_data", rdata_o, r.data);
            end
        end
`ifdef MEM_FORWARD_EN
        chk("fwd_vld", 32'(fwd), 32'(wrsd_o && (rd_o != 5'd0)));
`endif
    end

    task automatic push_acc(input logic [31:0] a, input logic wr, input logic [7:0] d);
        acc_t e;
        e.a = a; e.wr = wr; e.d = d;
        exp_acc.push_back(e);
    endtask

    task automatic push_res(input logic [4:0] rd, input logic [31:0] data);
        res_t r;
        r.rd = rd; r.data = data;
        exp_res.push_back(r);
    endtask

    // Issue one command and hold it while stall_o is high, as EX/MEM would.
    // gmask bit k is the grant in cycle k after issue.
    task automatic run_cmd(input logic [4:0] c, input logic [31:0] a, input logic [31:0] v,
                           input logic [4:0] rd, input logic [31:0] rdat, input logic w,
                           input logic [31:0] gmask, input int exp_stall, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        @(posedge clk); #1;
        cmd = c; addr_in = a; val_in = v; rd_in = rd; rdata_in = rdat; wr_in = w;
        gnt = gmask[0];
        for (int k = 0; k < 64 && !seen; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                gnt = (k < 32) ? gmask[k[4:0]] : 1'b1;
            end
            @(negedge clk);
            if (stall) n++;
            else seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout: stall still high after 64 cycles, required release", name);
        end
        chk({name, "_stall"}, 32'(n), 32'(exp_stall));
        if (is_store_cmd(c)) chk({name, "_st_wrsd"}, 32'(wrsd_o), 32'd0);
    endtask

    task automatic nop();
        @(posedge clk); #1;
        cmd = CMD_NOP; addr_in = '0; val_in = '0; rd_in = '0; rdata_in = '0; wr_in = 1'b0;
        gnt = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        cmd = CMD_NOP; addr_in = '0; val_in = '0; rd_in = '0; rdata_in = '0; wr_in = 1'b0;
        gnt = 1'b1;
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        mem[32'h20]  = 8'h80;
        mem[32'h40]  = 8'hFF; mem[32'h41]  = 8'hFF;
        mem[32'h50]  = 8'h00; mem[32'h51]  = 8'h80;
        mem[32'h200] = 8'h11; mem[32'h201] = 8'h22; mem[32'h202] = 8'h33; mem[32'h203] = 8'h44;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd", 32'(rd_o), 32'd0);
        chk("rst_data", rdata_o, 32'd0);
        chk("rst_wrsd", 32'(wrsd_o), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_wr", 32'(mem_wr), 32'd0);
        chk("rst_addr", mem_a, 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: ADDI passthrough
        push_res(5'd3, 32'h5);
        run_cmd(CMD_ADDI, 32'h0, 32'h0, 5'd3, 32'h5, 1'b1, 32'hFFFF_FFFF, 0, "addi");

        // 2: LW with grant held high
        for (int i = 0; i < 4; i++) push_acc(32'h100 + 32'(i), 1'b0, 8'h00);
        push_res(5'd5, 32'h1234_5678);
        run_cmd(CMD_LW, 32'h100, 32'h0, 5'd5, 32'h100, 1'b1, 32'hFFFF_FFFF, 6, "lw");

        // 3: load extension
        push_acc(32'h20, 1'b0, 8'h00);
        push_res(5'd6, 32'hFFFF_FF80);
        run_cmd(CMD_LB, 32'h20, 32'h0, 5'd6, 32'h0, 1'b1, 32'hFFFF_FFFF, 3, "lb");
        push_acc(32'h20, 1'b0, 8'h00);
        push_res(5'd7, 32'h0000_0080);
        run_cmd(CMD_LBU, 32'h20, 32'h0, 5'd7, 32'h0, 1'b1, 32'hFFFF_FFFF, 3, "lbu");
        push_acc(32'h40, 1'b0, 8'h00); push_acc(32'h41, 1'b0, 8'h00);
        push_res(5'd8, 32'h0000_FFFF);
        run_cmd(CMD_LHU, 32'h40, 32'h0, 5'd8, 32'h0, 1'b1, 32'hFFFF_FFFF, 4, "lhu");
        push_acc(32'h50, 1'b0, 8'h00); push_acc(32'h51, 1'b0, 8'h00);
        push_res(5'd9, 32'hFFFF_8000);
        run_cmd(CMD_LH, 32'h50, 32'h0, 5'd9, 32'h0, 1'b1, 32'hFFFF_FFFF, 4, "lh");

        // 4: SW little-endian, write_rsd_in high but no writeback, then read it back
        push_acc(32'h30000, 1'b1, 8'hEF); push_acc(32'h30001, 1'b1, 8'hBE);
        push_acc(32'h30002, 1'b1, 8'hAD); push_acc(32'h30003, 1'b1, 8'hDE);
        run_cmd(CMD_SW, 32'h30000, 32'hDEAD_BEEF, 5'd4, 32'h30000, 1'b1, 32'hFFFF_FFFF, 5, "sw");
        for (int i = 0; i < 4; i++) push_acc(32'h30000 + 32'(i), 1'b0, 8'h00);
        push_res(5'd10, 32'hDEAD_BEEF);
        run_cmd(CMD_LW, 32'h30000, 32'h0, 5'd10, 32'h0, 1'b1, 32'hFFFF_FFFF, 6, "lw_rb");

        // 5: LW with grant low for 3 cycles on the 2nd byte
        for (int i = 0; i < 4; i++) push_acc(32'h200 + 32'(i), 1'b0, 8'h00);
        push_res(5'd11, 32'h4433_2211);
        run_cmd(CMD_LW, 32'h200, 32'h0, 5'd11, 32'h0, 1'b1, 32'hFFFF_FFE3, 9, "lw_gap");

        // 6: SH across the top of the address space, then read back
        push_acc(32'hFFFF_FFFF, 1'b1, 8'hB2); push_acc(32'h0000_0000, 1'b1, 8'hA1);
        run_cmd(CMD_SH, 32'hFFFF_FFFF, 32'h0000_A1B2, 5'd0, 32'h0, 1'b0, 32'hFFFF_FFFF, 3, "sh_wrap");
        push_acc(32'hFFFF_FFFF, 1'b0, 8'h00); push_acc(32'h0000_0000, 1'b0, 8'h00);
        push_res(5'd12, 32'h0000_A1B2);
        run_cmd(CMD_LHU, 32'hFFFF_FFFF, 32'h0, 5'd12, 32'h0, 1'b1, 32'hFFFF_FFFF, 4, "lhu_wrap");

        // Non-writing ALU op and unknown command code both pass through
        run_cmd(CMD_ADD, 32'h0, 32'h0, 5'd4, 32'h99, 1'b0, 32'hFFFF_FFFF, 0, "add_nowr");
        push_res(5'd13, 32'h0000_CAFE);
        run_cmd(5'h1F, 32'h0, 32'h0, 5'd13, 32'hCAFE, 1'b1, 32'hFFFF_FFFF, 0, "unknown");

        // Reset during XFER: two bytes go out, then the transfer is abandoned
        push_acc(32'h300, 1'b0, 8'h00); push_acc(32'h301, 1'b0, 8'h00);
        @(posedge clk); #1;
        cmd = CMD_LW; addr_in = 32'h300; val_in = '0; rd_in = 5'd7; rdata_in = '0; wr_in = 1'b1;
        gnt = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstx_busy_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        cmd = CMD_NOP; addr_in = '0; rd_in = '0; wr_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstx_req", 32'(mem_req), 32'd0);
        chk("rstx_wr", 32'(mem_wr), 32'd0);
        chk("rstx_stall", 32'(stall), 32'd0);
        chk("rstx_wrsd", 32'(wrsd_o), 32'd0);
        chk("rstx_data", rdata_o, 32'd0);
        // FSM must be back in IDLE: passthrough takes one cycle
        push_res(5'd9, 32'h77);
        run_cmd(CMD_ADDI, 32'h0, 32'h0, 5'd9, 32'h77, 1'b1, 32'hFFFF_FFFF, 0, "addi_post_rst");

        nop();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
        chk("res_queue_empty", 32'(exp_res.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
